// File: rtl/ysyx_23060136_wbu_gpr_writer.sv
// rtl/ysyx_23060136_wbu_gpr_writer.sv - write-back stage driving the GPR write port
// Holds one retiring instruction, forms the register write, counts retirements, halts on ebreak.
module ysyx_23060136_wbu_gpr_writer #(
   parameter int GPR_W  = 5,
   parameter int BITS_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MEM_valid,
   output logic              MEM_ready,
   input  logic [BITS_W-1:0] MEM_pc,
   input  logic [31:0]       MEM_inst,
   input  logic [GPR_W-1:0]  MEM_rd,
   input  logic              MEM_RegWr,
   input  logic [1:0]        MEM_wb_sel,
   input  logic [BITS_W-1:0] MEM_alu_result,
   input  logic [BITS_W-1:0] MEM_load_raw,
   input  logic [BITS_W-1:0] MEM_csr_rdata,
   input  logic [2:0]        MEM_funct3,
   input  logic              MEM_ebreak,
   input  logic              WBU_flush,
   output logic              RegWr,
   output logic [GPR_W-1:0]  WBU_rd,
   output logic [BITS_W-1:0] rf_busW,
   output logic              WBU_commit,
   output logic [BITS_W-1:0] WBU_pc,
   output logic [31:0]       WBU_inst,
   output logic              WBU_halt,
   output logic [63:0]       WBU_instret
);

   typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

   state_t              r_state, w_state_next;
   logic                r_valid;
   logic [BITS_W-1:0]   r_pc, r_alu, r_raw, r_csr;
   logic [31:0]         r_inst;
   logic [GPR_W-1:0]    r_rd;
   logic                r_regwr, r_ebreak;
   logic [1:0]          r_sel;
   logic [2:0]          r_funct3;
   logic [63:0]         r_instret;

   logic                w_accept, w_commit;
   logic [7:0]          w_byte;
   logic [15:0]         w_half;
   logic [31:0]         w_word;
   logic [BITS_W-1:0]   w_load, w_wdata;

   assign w_accept = MEM_valid & MEM_ready;
   assign w_commit = r_valid & ~WBU_flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid  <= 1'b0;
         r_pc     <= '0;
         r_inst   <= '0;
         r_rd     <= '0;
         r_regwr  <= 1'b0;
         r_sel    <= '0;
         r_alu    <= '0;
         r_raw    <= '0;
         r_csr    <= '0;
         r_funct3 <= '0;
         r_ebreak <= 1'b0;
      end else begin
         r_valid <= w_accept;
         if (w_accept) begin
            r_pc     <= MEM_pc;
            r_inst   <= MEM_inst;
            r_rd     <= MEM_rd;
            r_regwr  <= MEM_RegWr;
            r_sel    <= MEM_wb_sel;
            r_alu    <= MEM_alu_result;
            r_raw    <= MEM_load_raw;
            r_csr    <= MEM_csr_rdata;
            r_funct3 <= MEM_funct3;
            r_ebreak <= MEM_ebreak;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_instret <= '0;
      else if (w_commit) r_instret <= r_instret + 64'd1;
   end

   // Sub-doubleword lanes selected by the low effective-address bits; finer bits are ignored.
   always_comb begin
      w_byte = r_raw[{r_alu[2:0], 3'b000} +: 8];
      w_half = r_raw[{r_alu[2:1], 4'b0000} +: 16];
      w_word = r_raw[{r_alu[2], 5'b00000} +: 32];
      case (r_funct3)
         3'd0:    w_load = {{(BITS_W-8){w_byte[7]}}, w_byte};
         3'd1:    w_load = {{(BITS_W-16){w_half[15]}}, w_half};
         3'd2:    w_load = {{(BITS_W-32){w_word[31]}}, w_word};
         3'd3:    w_load = r_raw;
         3'd4:    w_load = {{(BITS_W-8){1'b0}}, w_byte};
         3'd5:    w_load = {{(BITS_W-16){1'b0}}, w_half};
         3'd6:    w_load = {{(BITS_W-32){1'b0}}, w_word};
         default: w_load = '0;
      endcase
   end

   always_comb begin
      case (r_sel)
         2'd0:    w_wdata = r_alu;
         2'd1:    w_wdata = w_load;
         2'd2:    w_wdata = r_csr;
         default: w_wdata = r_pc + BITS_W'(4);
      endcase
   end

   assign RegWr       = r_valid & r_regwr & (r_rd != '0) & ~WBU_flush;
   assign WBU_rd      = r_valid ? r_rd    : '0;
   assign rf_busW     = r_valid ? w_wdata : '0;
   assign WBU_commit  = w_commit;
   assign WBU_pc      = r_valid ? r_pc    : '0;
   assign WBU_inst    = r_valid ? r_inst  : '0;
   assign WBU_instret = r_instret;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_RUN;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (r_state == S_RUN && w_commit && r_ebreak) w_state_next = S_HALT;
   end

   // MEM_ready is held low while rst is asserted so every output reads 0 during reset.
   always_comb begin
      MEM_ready = (r_state == S_RUN) & ~rst;
      WBU_halt  = (r_state == S_HALT);
   end

endmodule

// File: tb/tb_ysyx_23060136_wbu_gpr_writer.sv
// tb/tb_ysyx_23060136_wbu_gpr_writer.sv - directed self-checking bench for the write-back stage
module tb_ysyx_23060136_wbu_gpr_writer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        MEM_valid = 1'b0;
   logic        MEM_ready;
   logic [63:0] MEM_pc = '0;
   logic [31:0] MEM_inst = '0;
   logic [4:0]  MEM_rd = '0;
   logic        MEM_RegWr = 1'b0;
   logic [1:0]  MEM_wb_sel = '0;
   logic [63:0] MEM_alu_result = '0;
   logic [63:0] MEM_load_raw = '0;
   logic [63:0] MEM_csr_rdata = '0;
   logic [2:0]  MEM_funct3 = '0;
   logic        MEM_ebreak = 1'b0;
   logic        WBU_flush = 1'b0;
   logic        RegWr;
   logic [4:0]  WBU_rd;
   logic [63:0] rf_busW;
   logic        WBU_commit;
   logic [63:0] WBU_pc;
   logic [31:0] WBU_inst;
   logic        WBU_halt;
   logic [63:0] WBU_instret;

   int checks = 0;
   int errors = 0;

   localparam logic [63:0] RAW = 64'h8877_6655_4433_2211;

   ysyx_23060136_wbu_gpr_writer #(.GPR_W(5), .BITS_W(64)) dut (
      .clk(clk), .rst(rst),
      .MEM_valid(MEM_valid), .MEM_ready(MEM_ready),
      .MEM_pc(MEM_pc), .MEM_inst(MEM_inst), .MEM_rd(MEM_rd), .MEM_RegWr(MEM_RegWr),
      .MEM_wb_sel(MEM_wb_sel), .MEM_alu_result(MEM_alu_result), .MEM_load_raw(MEM_load_raw),
      .MEM_csr_rdata(MEM_csr_rdata), .MEM_funct3(MEM_funct3), .MEM_ebreak(MEM_ebreak),
      .WBU_flush(WBU_flush),
      .RegWr(RegWr), .WBU_rd(WBU_rd), .rf_busW(rf_busW), .WBU_commit(WBU_commit),
      .WBU_pc(WBU_pc), .WBU_inst(WBU_inst), .WBU_halt(WBU_halt), .WBU_instret(WBU_instret)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one instruction for one edge, then leave the bus idle; sample 1 time unit later.
   task automatic offer(input logic [63:0] pc, input logic [4:0] rd, input logic regwr,
                        input logic [1:0] sel, input logic [63:0] alu, input logic [63:0] raw,
                        input logic [63:0] csr, input logic [2:0] f3, input logic ebrk);
      MEM_valid = 1'b1; MEM_pc = pc; MEM_inst = pc[31:0] ^ 32'h0000_0013; MEM_rd = rd;
      MEM_RegWr = regwr; MEM_wb_sel = sel; MEM_alu_result = alu; MEM_load_raw = raw;
      MEM_csr_rdata = csr; MEM_funct3 = f3; MEM_ebreak = ebrk;
      @(posedge clk); #1;
      MEM_valid = 1'b0; MEM_ebreak = 1'b0;
   endtask

   task automatic idle();
      MEM_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic load(input string tag, input logic [63:0] addr, input logic [2:0] f3,
                       input logic [63:0] exp);
      offer(64'h100, 5'd10, 1'b1, 2'd1, addr, RAW, 64'h0, f3, 1'b0);
      check(tag, rf_busW, exp);
   endtask

   initial begin
      // reset state
      @(posedge clk); #1;
      check("rst_ready", MEM_ready, 0);
      check("rst_commit", WBU_commit, 0);
      check("rst_instret", WBU_instret, 0);
      rst = 1'b0;
      #1;
      check("rel_ready", MEM_ready, 1);

      // ALU write and rd=0
      offer(64'h8000_0000, 5'd5, 1'b1, 2'd0, 64'hDEAD_BEEF, 64'h0, 64'h0, 3'd0, 1'b0);
      check("alu_regwr", RegWr, 1);
      check("alu_rd", WBU_rd, 5);
      check("alu_busw", rf_busW, 64'hDEAD_BEEF);
      check("alu_commit", WBU_commit, 1);
      check("alu_pc", WBU_pc, 64'h8000_0000);
      check("alu_inst", WBU_inst, 32'h8000_0013);
      check("alu_cnt_during", WBU_instret, 0);
      offer(64'h8000_0004, 5'd0, 1'b1, 2'd0, 64'hDEAD_BEEF, 64'h0, 64'h0, 3'd0, 1'b0);
      check("rd0_regwr", RegWr, 0);
      check("rd0_commit", WBU_commit, 1);
      check("rd0_cnt_during", WBU_instret, 1);

      // load extraction
      load("lb5", 64'h1005, 3'd0, 64'h66);
      load("lb7", 64'h1007, 3'd0, 64'hFFFF_FFFF_FFFF_FF88);
      load("lhu6", 64'h1006, 3'd5, 64'h8877);
      load("lw4", 64'h1004, 3'd2, 64'hFFFF_FFFF_8877_6655);
      load("lwu0", 64'h1000, 3'd6, 64'h4433_2211);
      load("ld", 64'h1000, 3'd3, RAW);
      load("lh3", 64'h1003, 3'd1, 64'h0000_0000_0000_4433);
      load("f3_7", 64'h1000, 3'd7, 64'h0);

      // wb_sel 3 wraps, wb_sel 2 passes CSR
      offer(64'hFFFF_FFFF_FFFF_FFFC, 5'd1, 1'b1, 2'd3, 64'h5, 64'h0, 64'h0, 3'd0, 1'b0);
      check("pc4_wrap", rf_busW, 64'h0);
      offer(64'h200, 5'd2, 1'b1, 2'd2, 64'h5, 64'h0, 64'h1234_5678_9ABC_DEF0, 3'd0, 1'b0);
      check("csr_busw", rf_busW, 64'h1234_5678_9ABC_DEF0);
      check("cnt_before_rst", WBU_instret, 11);

      // asynchronous reset with an instruction held
      offer(64'h300, 5'd9, 1'b1, 2'd0, 64'h77, 64'h0, 64'h0, 3'd0, 1'b0);
      rst = 1'b1; #1;
      check("arst_regwr", RegWr, 0);
      check("arst_commit", WBU_commit, 0);
      check("arst_busw", rf_busW, 0);
      check("arst_rd", WBU_rd, 0);
      check("arst_pc", WBU_pc, 0);
      check("arst_instret", WBU_instret, 0);
      check("arst_ready", MEM_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0; #1;
      check("arst_rel_ready", MEM_ready, 1);
      idle();
      check("arst_no_write", RegWr, 0);
      check("arst_no_commit", WBU_commit, 0);
      check("arst_cnt", WBU_instret, 0);

      // back-to-back stream of 10
      MEM_valid = 1'b1; MEM_RegWr = 1'b1; MEM_rd = 5'd4; MEM_wb_sel = 2'd0;
      for (int i = 0; i < 10; i++) begin
         MEM_alu_result = 64'(i + 100);
         @(posedge clk); #1;
         check("strm_commit", WBU_commit, 1);
         check("strm_busw", rf_busW, 64'(i + 100));
      end
      MEM_valid = 1'b0;
      idle();
      check("strm_idle", WBU_commit, 0);
      check("strm_cnt", WBU_instret, 10);

      // flush a held write and a held ebreak
      offer(64'h400, 5'd7, 1'b1, 2'd0, 64'h99, 64'h0, 64'h0, 3'd0, 1'b0);
      WBU_flush = 1'b1; #1;
      check("fl_regwr", RegWr, 0);
      check("fl_commit", WBU_commit, 0);
      @(posedge clk); #1;
      WBU_flush = 1'b0;
      check("fl_cnt", WBU_instret, 10);
      offer(64'h404, 5'd0, 1'b0, 2'd0, 64'h0, 64'h0, 64'h0, 3'd0, 1'b1);
      WBU_flush = 1'b1;
      @(posedge clk); #1;
      WBU_flush = 1'b0;
      check("fl_eb_halt", WBU_halt, 0);
      check("fl_eb_ready", MEM_ready, 1);
      check("fl_eb_cnt", WBU_instret, 10);

      // ebreak halts; the instruction accepted alongside its commit still retires once
      offer(64'h500, 5'd0, 1'b0, 2'd0, 64'h0, 64'h0, 64'h0, 3'd0, 1'b1);
      check("eb_commit", WBU_commit, 1);
      check("eb_halt_early", WBU_halt, 0);
      check("eb_ready_still", MEM_ready, 1);
      check("eb_cnt_during", WBU_instret, 10);
      offer(64'h504, 5'd3, 1'b1, 2'd0, 64'h55, 64'h0, 64'h0, 3'd0, 1'b0);
      check("hlt_halt", WBU_halt, 1);
      check("hlt_ready", MEM_ready, 0);
      check("hlt_tail_commit", WBU_commit, 1);
      check("hlt_tail_busw", rf_busW, 64'h55);
      check("hlt_tail_pc", WBU_pc, 64'h504);
      offer(64'h508, 5'd6, 1'b1, 2'd0, 64'h66, 64'h0, 64'h0, 3'd0, 1'b0);
      check("hlt_no_accept", WBU_commit, 0);
      check("hlt_no_write", RegWr, 0);
      check("hlt_cnt", WBU_instret, 12);
      idle();
      check("hlt_stays", WBU_halt, 1);
      check("hlt_cnt_final", WBU_instret, 12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_23060136_wbu_gpr_writer.md
# ysyx_23060136_wbu_gpr_writer

Write-back stage for the RV64IM core: drives the write port of the IDU general-purpose register file. It accepts retiring instructions from MEM over a valid/ready handshake and holds each one in a single pipeline register. For loads it extracts and extends the load data, selects the final write value, and presents `RegWr`/`WBU_rd`/`rf_busW` for one cycle per instruction. It also counts retired instructions and halts the pipeline on `ebreak`.

## Interface
- `GPR_W`, 5, register index width (matches `ysyx_23060136_GPR_W`)
- `BITS_W`, 64, datapath width (matches `ysyx_23060136_BITS_W`)
- `clk`  in  1  core clock; everything on posedge
- `rst`  in  1  reset, asynchronous, active-high
- `MEM_valid`  in  1  MEM offers an instruction
- `MEM_ready`  out  1  WBU can accept this cycle
- `MEM_pc`  in  BITS_W  PC of offered instruction
- `MEM_inst`  in  32  instruction word
- `MEM_rd`  in  GPR_W  destination register
- `MEM_RegWr`  in  1  instruction writes rd
- `MEM_wb_sel`  in  2  source select: 0=ALU, 1=load, 2=CSR, 3=PC+4
- `MEM_alu_result`  in  BITS_W  ALU result; for loads, the effective address
- `MEM_load_raw`  in  BITS_W  aligned 64-bit doubleword read from memory
- `MEM_csr_rdata`  in  BITS_W  old CSR value
- `MEM_funct3`  in  3  load size/sign (LB 0, LH 1, LW 2, LD 3, LBU 4, LHU 5, LWU 6)
- `MEM_ebreak`  in  1  instruction is `ebreak`
- `WBU_flush`  in  1  kill the held instruction (no write, no count)
- `RegWr`  out  1  register-file write enable
- `WBU_rd`  out  GPR_W  register-file write index
- `rf_busW`  out  BITS_W  register-file write data
- `WBU_commit`  out  1  one instruction retired this cycle
- `WBU_pc`  out  BITS_W  PC of retiring instruction
- `WBU_inst`  out  32  retiring instruction
- `WBU_halt`  out  1  core halted by `ebreak`
- `WBU_instret`  out  64  retired-instruction count

## Operation
- **Pipeline register.** Holds `wb_valid` plus all MEM fields.
  - Loads when `MEM_valid & MEM_ready`.
  - Otherwise `wb_valid` clears at the next edge.
  - WBU never stalls in RUN, so `MEM_ready = (state==RUN)`.
- **Load extract.** Index the raw doubleword by `addr[2:0]`, where addr = held `MEM_alu_result`.
  - byte = `raw[8*addr[2:0] +: 8]`; half uses `addr[2:1]`; word uses `addr[2]`.
  - LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend; LD passes the full 64 bits.
  - funct3=7 yields 0.
  - Misaligned accesses are not checked; low address bits beyond the access size are ignored.
- **Write value.** `rf_busW` is selected by `wb_sel`: ALU result, extracted load, CSR data, or `pc+4` (64-bit wrap).
- **Write enable.** `RegWr = wb_valid & held_RegWr & (rd!=0) & ~WBU_flush`.
  - `WBU_rd`/`rf_busW` are driven whenever `wb_valid`; they are 0 when not valid.
- **Commit.** `WBU_commit = wb_valid & ~WBU_flush`.
  - `WBU_pc`/`WBU_inst` reflect the held instruction.
  - Instructions with rd=0 still commit.
- **Counter.** `WBU_instret` increments by 1 on each commit and wraps at 2^64.
- **FSM.**
  - RUN → HALT when a committing instruction has `ebreak` set.
  - HALT is absorbing until `rst`.
  - In HALT: `MEM_ready=0`; no further loads; `WBU_halt=1`.
- **Flush.** `WBU_flush` affects only the instruction held in the current cycle.
  - A flushed `ebreak` does not halt.
  - Flush does not block a simultaneous accept from MEM.

## Timing
- **Reset.** `rst` asserted asynchronously sets:
  - `wb_valid=0`, state=RUN, `WBU_instret=0`
  - all outputs 0, except `MEM_ready`, which is 1 once `rst` deasserts.
- **Reset mid-operation.** The held instruction is discarded and never written.
- **Latency.** An instruction accepted at edge N drives `RegWr`/`WBU_commit` during cycle N..N+1. The register file captures it at edge N+1.
- **Throughput.** One instruction per cycle, back-to-back, with no bubbles inserted.
- **Counter visibility.** The counter updates at the edge ending the commit cycle. During a commit cycle it shows the count excluding the current instruction.
- **`ebreak` timing.**
  - The `ebreak` itself commits, and is counted.
  - `MEM_ready` drops in the cycle after the `ebreak` commit cycle.
  - Whatever MEM offers in the `ebreak` commit cycle is still accepted. It commits one cycle later; this matches the in-order squash done upstream by the halt logic.
- **Combinational outputs.** All outputs are combinational from the registers plus `WBU_flush`. There is no combinational path from `MEM_*` to outputs except `MEM_ready`, which depends only on state.

## Test plan
- **Reset.** Assert `rst` mid-stream with `wb_valid=1` → all outputs 0 immediately; after release `MEM_ready=1`, `WBU_instret=0`, and no write of the held instruction.
- **ALU and rd=0.**
  - ALU op, rd=5, result 0xDEAD_BEEF → next cycle `RegWr=1`, `WBU_rd=5`, `rf_busW=0xDEADBEEF`, `WBU_commit=1`.
  - Same op with rd=0 → `RegWr=0`, `WBU_commit=1`.
- **Load extract.** raw=0x8877_6655_4433_2211:
  - LB addr..5 → 0x66; LB addr..7 → 0xFFFF_FFFF_FFFF_FF88.
  - LHU addr..6 → 0x8877; LW addr..4 → 0xFFFF_FFFF_8877_6655.
  - LWU addr..0 → 0x4433_2211; LD → raw.
- **Select and stream.**
  - `wb_sel`=3 with pc=0xFFFF_FFFF_FFFF_FFFC → `rf_busW=0`.
  - `wb_sel`=2 → CSR data.
  - 10 back-to-back valid instructions → 10 consecutive commits, `WBU_instret=10`.
- **Flush.** Flush asserted while a write to rd=7 is held → no write, no count. Flushed `ebreak` → `WBU_halt` stays 0.
- **Halt.** `ebreak` committed → `WBU_halt=1` and `MEM_ready=0` from the next cycle. The following instruction already accepted commits exactly once, after which there are no more commits; counter = prior + 2.
